instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the CPU datapath.
- Owns the program counter and issues word reads to the synchronous block RAM (1-cycle read latency).
- Latches the returned word into the instruction register and hands it to the datapath over a valid/ready handshake.
- Accepts branch/jump redirects from the datapath and flushes in-flight fetches.

Parameters:
- ADDR_WIDTH, 16, PC and RAM address width (word addressed).
- RESET_PC, 16'h0000, PC value after reset.
- LINK_DEPTH, 4, return-link stack entries; used only with FETCH_LINK_STACK_EN.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  fetch enable.
- ram_read_en  out  1  read strobe to block RAM.
- ram_read_addr  out  ADDR_WIDTH  read address; equals current PC.
- ram_q  in  16  RAM data, valid the cycle after ram_read_en.
- instr  out  16  instruction register contents.
- instr_pc  out  ADDR_WIDTH  address instr was fetched from.
- instr_valid  out  1  instr holds an unconsumed instruction.
- instr_ready  in  1  datapath accepts instr this cycle.
- redirect  in  1  load new PC, flush.
- redirect_addr  in  ADDR_WIDTH  redirect target.
- link_push  in  1  push instr_pc+1 (JAL); optional feature.
- link_pop  in  1  pop link stack; optional feature.
- link_top  out  ADDR_WIDTH  top of link stack; optional feature.
- link_empty  out  1  link stack empty; optional feature.

Behaviour:
- Reset (reset=0, async): PC=RESET_PC, state=IDLE, instr=0, instr_pc=0, instr_valid=0, ram_read_en=0, link stack cleared, link_top=0, link_empty=1.
- FSM states: IDLE, ISSUE, CAPTURE, HOLD.
- IDLE: ram_read_en=0. If run=1, go to ISSUE next cycle.
- ISSUE: ram_read_en=1, ram_read_addr=PC; go to CAPTURE.
- CAPTURE: instr<=ram_q, instr_pc<=PC, instr_valid<=1, PC<=PC+1; go to HOLD.
- HOLD: instr_valid=1 and instr/instr_pc are stable until accepted.
  - Handshake: instr_valid & instr_ready. On that edge instr_valid<=0.
  - On handshake with run=1: ram_read_en=1 in the same cycle; go to CAPTURE. Steady-state throughput is 1 instruction per 2 cycles.
  - On handshake with run=0: go to IDLE.
  - Without a handshake, stay in HOLD.
- Latency: the first instruction is valid 3 cycles after run rises from IDLE.
- PC arithmetic is modulo 2^ADDR_WIDTH: 16'hFFFF+1 -> 16'h0000, no flag.
- Redirect, any state except reset:
  - PC<=redirect_addr, instr_valid<=0.
  - A read issued this or the previous cycle is discarded: the CAPTURE load is suppressed.
  - Next state is ISSUE if run=1, else IDLE.
  - Redirect has priority over capture and PC increment.
  - Redirect together with a handshake: the held instruction counts as consumed; the next fetch is from redirect_addr.
- run falling mid-fetch: an in-flight CAPTURE completes; the word is held in HOLD until accepted, then the FSM goes to IDLE. No new reads are issued while run=0.
- Reset asserted mid-operation: immediate return to reset values. A RAM read in flight is ignored.

Optional Feature:
- Macro FETCH_LINK_STACK_EN.
- Defined: LINK_DEPTH-entry return-link stack.
  - link_push (sampled only on a handshake cycle) pushes instr_pc+1.
  - link_pop removes the top entry.
  - Push when full drops the oldest entry (circular).
  - Pop when empty is ignored.
  - Push and pop together replace the top entry; depth is unchanged.
  - link_top shows the current top (0 when empty). link_empty=1 when depth=0.
- Undefined: no stack logic; link_top=0, link_empty=1, link_push/link_pop ignored.

Test Plan:
- Reset release, run=1, RAM[0..2]=16'h1111/2222/3333, instr_ready=1 -> instrs 1111@0, 2222@1, 3333@2, valid every 2nd cycle; first valid on cycle 3.
- instr_ready=0 for 5 cycles in HOLD -> instr=1111, instr_pc=0 stable; ram_read_en=0; PC=1; accepted on ready.
- In CAPTURE, redirect=1 with redirect_addr=16'h0040 -> stale ram_q not loaded; instr_valid=0; next instr_pc=16'h0040.
- Redirect to 16'hFFFF, run=1 -> instr_pc=FFFF, then 0000 (wrap).
- run dropped during ISSUE -> word captured and held; after accept the FSM is IDLE and ram_read_en stays 0. Async reset mid-HOLD -> instr_valid=0 immediately, PC=RESET_PC.
- With FETCH_LINK_STACK_EN, LINK_DEPTH=4: 5 pushes at instr_pc=10..14 -> link_top=15, the entry 11 is dropped; 4 pops -> link_empty=1; a 5th pop leaves link_top=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit -- fetch stage in front of the CPU datapath.
//
// Owns the program counter, issues word reads to a synchronous block RAM
// (1-cycle read latency), captures the returned word into the instruction
// register and presents it to the datapath over a valid/ready handshake.
// Branch/jump redirects reload the PC and discard any fetch in flight.
//
// Optional feature: define FETCH_LINK_STACK_EN to build a LINK_DEPTH-entry
// circular return-link stack; otherwise link_top=0 and link_empty=1.
//
// Ports:
//   clock          rising-edge system clock
//   reset          asynchronous active-low reset
//   run            fetch enable
//   ram_read_en    read strobe to block RAM
//   ram_read_addr  read address (current PC)
//   ram_q          RAM data, valid the cycle after ram_read_en
//   instr          instruction register
//   instr_pc       address instr was fetched from
//   instr_valid    instr holds an unconsumed instruction
//   instr_ready    datapath accepts instr this cycle
//   redirect       load redirect_addr into PC and flush
//   redirect_addr  redirect target
//   link_push      push instr_pc+1 on a handshake cycle (link stack)
//   link_pop       pop link stack
//   link_top       top of link stack, 0 when empty
//   link_empty     link stack empty
module instr_fetch_unit #(
   parameter int unsigned            ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = 16'h0000,
   parameter int unsigned            LINK_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  run,
   output logic                  ram_read_en,
   output logic [ADDR_WIDTH-1:0] ram_read_addr,
   input  logic [15:0]           ram_q,
   output logic [15:0]           instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   input  logic                  link_push,
   input  logic                  link_pop,
   output logic [ADDR_WIDTH-1:0] link_top,
   output logic                  link_empty
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

   state_t                state;
   state_t                next_state;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  handshake;
   logic                  do_capture;

   assign handshake     = instr_valid & instr_ready;
   assign ram_read_addr = pc;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A redirect never leads to CAPTURE, so any read issued in this or the
   // previous cycle is dropped simply by suppressing the capture here and
   // steering the next state away from CAPTURE.
   always_comb begin
      next_state  = state;
      ram_read_en = 1'b0;
      do_capture  = 1'b0;
      unique case (state)
         IDLE: begin
            if (run) next_state = ISSUE;
         end
         ISSUE: begin
            ram_read_en = 1'b1;
            next_state  = CAPTURE;
         end
         CAPTURE: begin
            do_capture = 1'b1;
            next_state = HOLD;
         end
         HOLD: begin
            if (handshake) begin
               if (run) begin
                  ram_read_en = 1'b1;
                  next_state  = CAPTURE;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
      if (redirect) begin
         do_capture = 1'b0;
         next_state = run ? ISSUE : IDLE;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc          <= RESET_PC;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else if (redirect) begin
         pc          <= redirect_addr;
         instr_valid <= 1'b0;
      end else if (do_capture) begin
         instr       <= ram_q;
         instr_pc    <= pc;
         instr_valid <= 1'b1;
         pc          <= pc + 1'b1;
      end else if (handshake) begin
         instr_valid <= 1'b0;
      end
   end

`ifdef FETCH_LINK_STACK_EN
   localparam int unsigned PTR_W = (LINK_DEPTH > 1) ? $clog2(LINK_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(LINK_DEPTH + 1);

   logic [ADDR_WIDTH-1:0] link_mem [LINK_DEPTH];
   logic [PTR_W-1:0]      link_ptr;
   logic [CNT_W-1:0]      link_cnt;
   logic [PTR_W-1:0]      ptr_inc;
   logic [PTR_W-1:0]      ptr_dec;
   logic                  do_push;
   logic                  do_pop;

   assign do_push = link_push & handshake;
   assign do_pop  = link_pop & (link_cnt != '0);
   assign ptr_inc = (link_ptr == PTR_W'(LINK_DEPTH - 1)) ? '0 : link_ptr + 1'b1;
   assign ptr_dec = (link_ptr == '0) ? PTR_W'(LINK_DEPTH - 1) : link_ptr - 1'b1;

   // link_ptr addresses the top entry; a push into a full stack lands on
   // the slot after the top, which is the oldest entry, so it is dropped.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         link_ptr <= '0;
         link_cnt <= '0;
         for (int unsigned i = 0; i < LINK_DEPTH; i++) link_mem[i] <= '0;
      end else if (do_push && do_pop) begin
         link_mem[link_ptr] <= instr_pc + 1'b1;
      end else if (do_push) begin
         link_mem[ptr_inc] <= instr_pc + 1'b1;
         link_ptr          <= ptr_inc;
         if (link_cnt != CNT_W'(LINK_DEPTH)) link_cnt <= link_cnt + 1'b1;
      end else if (do_pop) begin
         link_ptr <= ptr_dec;
         link_cnt <= link_cnt - 1'b1;
      end
   end

   assign link_empty = (link_cnt == '0);
   assign link_top   = link_empty ? '0 : link_mem[link_ptr];
`else
   localparam int unsigned UNUSED_LINK_DEPTH = LINK_DEPTH;
   logic unused_link;

   assign unused_link = link_push ^ link_pop;
   assign link_top    = '0;
   assign link_empty  = 1'b1;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        run;
   logic        ram_read_en;
   logic [15:0] ram_read_addr;
   logic [15:0] ram_q = 16'h0000;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [15:0] redirect_addr;
   logic        link_push;
   logic        link_pop;
   logic [15:0] link_top;
   logic        link_empty;

   logic [15:0] mem [0:65535];
   int          total = 0;
   int          bad   = 0;

`ifdef FETCH_LINK_STACK_EN
   localparam bit LS = 1'b1;
`else
   localparam bit LS = 1'b0;
`endif

   instr_fetch_unit #(
      .ADDR_WIDTH (16),
      .RESET_PC   (16'h0000),
      .LINK_DEPTH (4)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .run           (run),
      .ram_read_en   (ram_read_en),
      .ram_read_addr (ram_read_addr),
      .ram_q         (ram_q),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .link_push     (link_push),
      .link_pop      (link_pop),
      .link_top      (link_top),
      .link_empty    (link_empty)
   );

   always #5 clock = ~clock;

   // synchronous block RAM, 1-cycle read latency
   always @(posedge clock) begin
      if (ram_read_en) ram_q <= mem[ram_read_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
      mem[16'h0000] = 16'h1111;
      mem[16'h0001] = 16'h2222;
      mem[16'h0002] = 16'h3333;
      mem[16'h0040] = 16'hA040;
      mem[16'hFFFF] = 16'hBFFF;

      reset = 1'b0; run = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
      redirect_addr = 16'h0000; link_push = 1'b0; link_pop = 1'b0;

      // reset state
      #1;
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_ipc", instr_pc, 16'h0000);
      chk("rst_en", ram_read_en, 0);
      chk("rst_pc", ram_read_addr, 16'h0000);
      chk("rst_ltop", link_top, 16'h0000);
      chk("rst_lempty", link_empty, 1);
      tick();
      chk("rst_hold_en", ram_read_en, 0);

      // streaming fetch, ready always high
      reset = 1'b1; run = 1'b1; instr_ready = 1'b1;
      tick();
      chk("a1_en", ram_read_en, 1);
      chk("a1_addr", ram_read_addr, 16'h0000);
      chk("a1_valid", instr_valid, 0);
      tick();
      chk("a2_en", ram_read_en, 0);
      chk("a2_valid", instr_valid, 0);
      tick();
      chk("a3_valid", instr_valid, 1);
      chk("a3_instr", instr, 16'h1111);
      chk("a3_ipc", instr_pc, 16'h0000);
      chk("a3_en", ram_read_en, 1);
      chk("a3_addr", ram_read_addr, 16'h0001);
      tick();
      chk("a4_valid", instr_valid, 0);
      tick();
      chk("a5_valid", instr_valid, 1);
      chk("a5_instr", instr, 16'h2222);
      chk("a5_ipc", instr_pc, 16'h0001);
      tick();
      chk("a6_valid", instr_valid, 0);
      tick();
      chk("a7_valid", instr_valid, 1);
      chk("a7_instr", instr, 16'h3333);
      chk("a7_ipc", instr_pc, 16'h0002);

      // asynchronous reset in HOLD
      instr_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("ar_valid", instr_valid, 0);
      chk("ar_instr", instr, 16'h0000);
      chk("ar_pc", ram_read_addr, 16'h0000);
      chk("ar_en", ram_read_en, 0);
      tick();
      reset = 1'b1;

      // stall in HOLD with ready low
      tick();
      tick();
      tick();
      chk("c_valid", instr_valid, 1);
      chk("c_instr", instr, 16'h1111);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("c_stall_instr", instr, 16'h1111);
         chk("c_stall_ipc", instr_pc, 16'h0000);
         chk("c_stall_valid", instr_valid, 1);
         chk("c_stall_en", ram_read_en, 0);
         chk("c_stall_pc", ram_read_addr, 16'h0001);
      end
      instr_ready = 1'b1;
      #1;
      chk("c_accept_en", ram_read_en, 1);
      tick();
      chk("c_after_valid", instr_valid, 0);

      // redirect during CAPTURE: stale word (2222) must not load
      redirect = 1'b1; redirect_addr = 16'h0040;
      tick();
      chk("d_valid", instr_valid, 0);
      chk("d_instr", instr, 16'h1111);
      chk("d_pc", ram_read_addr, 16'h0040);
      redirect = 1'b0;
      chk("d_en", ram_read_en, 1);
      tick();
      tick();
      chk("d_new_valid", instr_valid, 1);
      chk("d_new_instr", instr, 16'hA040);
      chk("d_new_ipc", instr_pc, 16'h0040);

      // redirect together with handshake to FFFF, then wrap to 0000
      redirect = 1'b1; redirect_addr = 16'hFFFF;
      tick();
      chk("e_valid", instr_valid, 0);
      chk("e_instr", instr, 16'hA040);
      chk("e_pc", ram_read_addr, 16'hFFFF);
      redirect = 1'b0;
      tick();
      tick();
      chk("e_ffff_instr", instr, 16'hBFFF);
      chk("e_ffff_ipc", instr_pc, 16'hFFFF);
      chk("e_wrap_pc", ram_read_addr, 16'h0000);
      tick();
      tick();
      chk("e_wrap_valid", instr_valid, 1);
      chk("e_wrap_instr", instr, 16'h1111);
      chk("e_wrap_ipc", instr_pc, 16'h0000);

      // run dropped during ISSUE
      instr_ready = 1'b0; redirect = 1'b1; redirect_addr = 16'h0002;
      tick();
      chk("f_valid", instr_valid, 0);
      redirect = 1'b0; run = 1'b0;
      chk("f_issue_en", ram_read_en, 1);
      tick();
      chk("f_cap_en", ram_read_en, 0);
      tick();
      chk("f_hold_valid", instr_valid, 1);
      chk("f_hold_instr", instr, 16'h3333);
      chk("f_hold_ipc", instr_pc, 16'h0002);
      tick();
      chk("f_hold2_valid", instr_valid, 1);
      chk("f_hold2_en", ram_read_en, 0);
      instr_ready = 1'b1;
      #1;
      chk("f_accept_en", ram_read_en, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("f_idle_en", ram_read_en, 0);
         chk("f_idle_valid", instr_valid, 0);
         chk("f_idle_pc", ram_read_addr, 16'h0003);
      end

      // link stack: pushes at instr_pc 10..14, then pops
      run = 1'b1; redirect = 1'b1; redirect_addr = 16'h000A; link_push = 1'b1;
      tick();
      redirect = 1'b0;
      tick();
      chk("g_nopush_empty", link_empty, 1);
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("g_push_ipc", instr_pc, 32'(10 + k));
         chk("g_push_valid", instr_valid, 1);
         tick();
         chk("g_push_top", link_top, LS ? 32'(11 + k) : 32'd0);
         chk("g_push_empty", link_empty, LS ? 32'd0 : 32'd1);
         if (k == 4) begin
            run = 1'b0; instr_ready = 1'b0; link_push = 1'b0;
         end
         tick();
      end
      chk("g_hold_ipc", instr_pc, 16'h000F);
      link_pop = 1'b1;
      tick();
      chk("g_pop1_top", link_top, LS ? 32'd14 : 32'd0);
      tick();
      chk("g_pop2_top", link_top, LS ? 32'd13 : 32'd0);
      tick();
      chk("g_pop3_top", link_top, LS ? 32'd12 : 32'd0);
      chk("g_pop3_empty", link_empty, LS ? 32'd0 : 32'd1);
      tick();
      chk("g_pop4_top", link_top, 16'h0000);
      chk("g_pop4_empty", link_empty, 1);
      tick();
      chk("g_pop5_top", link_top, 16'h0000);
      chk("g_pop5_empty", link_empty, 1);
      link_pop = 1'b0;
      chk("g_final_ipc", instr_pc, 16'h000F);
      chk("g_final_valid", instr_valid, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
